// File: rtl/sync_fifo_s1_sf_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO and its control block.
package sync_fifo_s1_sf_pkg;

    typedef enum int {
        STICKY_PTR = 0,
        STICKY     = 1,
        NONSTICKY  = 2
    } err_mode_e;

    typedef enum int {
        SYNC_MEM   = 2,
        SYNC_NOMEM = 3
    } rst_mode_e;

    // Count must represent 0..words inclusive.
    function automatic int cntWidth(input int words);
        return $clog2(words + 1);
    endfunction

    function automatic int ptrWidth(input int words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/sync_fifo_s1_sf_ctl.sv
// FIFO control: read/write pointers, word count, registered status flags and error tracking.
module sync_fifo_s1_sf_ctl
    import sync_fifo_s1_sf_pkg::*;
#(
    parameter int depth    = 4,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_req_n,
    input  logic                       pop_req_n,
    output logic                       wrEn,
    output logic [ptrWidth(depth)-1:0] wrAddr,
    output logic [ptrWidth(depth)-1:0] rdAddr,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       half_full,
    output logic                       almost_full,
    output logic                       full,
    output logic                       error
);

    localparam int PtrW = ptrWidth(depth);
    localparam int CntW = cntWidth(depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(depth);
    localparam logic [CntW-1:0] AeCnt    = CntW'(ae_level);
    localparam logic [CntW-1:0] HfCnt    = CntW'((depth + 1) / 2);
    localparam logic [CntW-1:0] AfCnt    = CntW'(depth - af_level);

    logic [PtrW-1:0] wrPtrReg, wrPtrNext, rdPtrReg, rdPtrNext;
    logic [CntW-1:0] countReg, countNext, ptrSpan;
    logic            emptyReg, almostEmptyReg, halfFullReg, almostFullReg, fullReg, errorReg;
    logic            pushOk, popOk, overflow, underflow, ptrMismatch, errorNext;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] bumpPtr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        pushOk    = ~push_req_n & ~fullReg;
        popOk     = ~pop_req_n & ~emptyReg;
        overflow  = ~push_req_n & fullReg;
        underflow = ~pop_req_n & emptyReg;
        wrPtrNext = pushOk ? bumpPtr(wrPtrReg) : wrPtrReg;
        rdPtrNext = popOk ? bumpPtr(rdPtrReg) : rdPtrReg;
        countNext = countReg;
        if (pushOk && !popOk) begin
            countNext = countReg + 1'b1;
        end else if (popOk && !pushOk) begin
            countNext = countReg - 1'b1;
        end
        // A full FIFO has equal pointers, so the pointer span reads as zero.
        ptrSpan = (wrPtrReg >= rdPtrReg) ? CntW'(wrPtrReg) - CntW'(rdPtrReg)
                                         : CntW'(wrPtrReg) + DepthCnt - CntW'(rdPtrReg);
        ptrMismatch = ptrSpan != ((countReg == DepthCnt) ? '0 : countReg);
        if (err_mode == int'(NONSTICKY)) begin
            errorNext = overflow | underflow;
        end else if (err_mode == int'(STICKY)) begin
            errorNext = errorReg | overflow | underflow;
        end else begin
            errorNext = errorReg | overflow | underflow | ptrMismatch;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtrReg       <= '0;
            rdPtrReg       <= '0;
            countReg       <= '0;
            emptyReg       <= 1'b1;
            almostEmptyReg <= 1'b1;
            halfFullReg    <= 1'b0;
            almostFullReg  <= 1'b0;
            fullReg        <= 1'b0;
            errorReg       <= 1'b0;
        end else begin
            wrPtrReg       <= wrPtrNext;
            rdPtrReg       <= rdPtrNext;
            countReg       <= countNext;
            emptyReg       <= countNext == '0;
            almostEmptyReg <= countNext <= AeCnt;
            halfFullReg    <= countNext >= HfCnt;
            almostFullReg  <= countNext >= AfCnt;
            fullReg        <= countNext == DepthCnt;
            errorReg       <= errorNext;
        end
    end

    assign wrEn         = pushOk;
    assign wrAddr       = wrPtrReg;
    assign rdAddr       = rdPtrReg;
    assign empty        = emptyReg;
    assign almost_empty = almostEmptyReg;
    assign half_full    = halfFullReg;
    assign almost_full  = almostFullReg;
    assign full         = fullReg;
    assign error        = errorReg;

endmodule

// File: rtl/sync_fifo_s1_sf.sv
// Single-clock FIFO: word storage with a combinational head-word read; control lives in sync_fifo_s1_sf_ctl.
module sync_fifo_s1_sf
    import sync_fifo_s1_sf_pkg::*;
#(
    parameter int width    = 32,
    parameter int depth    = 4,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = 2,
    parameter int rst_mode = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req_n,
    input  logic             pop_req_n,
    input  logic             diag_n,
    input  logic [width-1:0] data_in,
    output logic             empty,
    output logic             almost_empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             full,
    output logic             error,
    output logic [width-1:0] data_out
);

    localparam int PtrW = ptrWidth(depth);

    if (width < 1 || width > 256) begin : gBadWidth
        $error("sync_fifo_s1_sf: width %0d outside 1..256", width);
    end
    if (depth < 2 || depth > 256) begin : gBadDepth
        $error("sync_fifo_s1_sf: depth %0d outside 2..256", depth);
    end
    if (ae_level < 1 || ae_level > depth - 1) begin : gBadAe
        $error("sync_fifo_s1_sf: ae_level %0d outside 1..depth-1", ae_level);
    end
    if (af_level < 1 || af_level > depth - 1) begin : gBadAf
        $error("sync_fifo_s1_sf: af_level %0d outside 1..depth-1", af_level);
    end
    if (err_mode < 0 || err_mode > 2) begin : gBadErr
        $error("sync_fifo_s1_sf: err_mode %0d outside 0..2", err_mode);
    end
    if (rst_mode != 2 && rst_mode != 3) begin : gBadRst
        $error("sync_fifo_s1_sf: rst_mode %0d must be 2 or 3", rst_mode);
    end

    logic [width-1:0] memReg [depth];
    logic             wrEn;
    logic [PtrW-1:0]  wrAddr, rdAddr;
    logic             unusedDiag;

    assign unusedDiag = diag_n;

    sync_fifo_s1_sf_ctl #(
        .depth    (depth),
        .ae_level (ae_level),
        .af_level (af_level),
        .err_mode (err_mode)
    ) ctl (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_req_n   (push_req_n),
        .pop_req_n    (pop_req_n),
        .wrEn         (wrEn),
        .wrAddr       (wrAddr),
        .rdAddr       (rdAddr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .half_full    (half_full),
        .almost_full  (almost_full),
        .full         (full),
        .error        (error)
    );

    // Reset never writes a word; it only clears storage when rst_mode asks for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (rst_mode == int'(SYNC_MEM)) begin
                for (int i = 0; i < depth; i++) begin
                    memReg[i] <= '0;
                end
            end
        end else if (wrEn) begin
            memReg[wrAddr] <= data_in;
        end
    end

    assign data_out = memReg[rdAddr];

endmodule

// File: tb/tb_sync_fifo_s1_sf.sv
// Bench: two FIFO instances (err_mode 2/rst_mode 3 and err_mode 1/rst_mode 2) checked against a queue model.
module tb_sync_fifo_s1_sf;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n, push_req_n, pop_req_n, diag_n;
    logic [31:0] data_in;
    logic        emptyA, almostEmptyA, halfFullA, almostFullA, fullA, errorA;
    logic        emptyB, almostEmptyB, halfFullB, almostFullB, fullB, errorB;
    logic [31:0] dataOutA, dataOutB;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] mdlQ[$];
    logic [31:0] memA [D];
    logic [31:0] memB [D];
    bit          knownA [D];
    bit          knownB [D];
    int          mdlRd = 0;
    bit          errA = 0;
    bit          errB = 0;

    always #5 clk = ~clk;

    sync_fifo_s1_sf #(
        .width(32), .depth(D), .ae_level(1), .af_level(1), .err_mode(2), .rst_mode(3)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
        .diag_n(diag_n), .data_in(data_in), .empty(emptyA), .almost_empty(almostEmptyA),
        .half_full(halfFullA), .almost_full(almostFullA), .full(fullA), .error(errorA),
        .data_out(dataOutA)
    );

    sync_fifo_s1_sf #(
        .width(32), .depth(D), .ae_level(1), .af_level(1), .err_mode(1), .rst_mode(2)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
        .diag_n(diag_n), .data_in(data_in), .empty(emptyB), .almost_empty(almostEmptyB),
        .half_full(halfFullB), .almost_full(almostFullB), .full(fullB), .error(errorB),
        .data_out(dataOutB)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rstn, input logic pushn, input logic popn, input logic [31:0] d);
        int          sz;
        int          wrIdx;
        bit          ovf, unf, doPush, doPop;
        logic [4:0]  expFlags;
        logic [31:0] expA, expB;
        rst_n      = rstn;
        push_req_n = pushn;
        pop_req_n  = popn;
        data_in    = d;
        @(posedge clk);
        sz = mdlQ.size();
        if (!rstn) begin
            mdlQ.delete();
            mdlRd = 0;
            errA  = 0;
            errB  = 0;
            for (int i = 0; i < D; i++) begin
                memB[i]   = '0;
                knownB[i] = 1'b1;
            end
        end else begin
            ovf    = !pushn && sz == D;
            unf    = !popn && sz == 0;
            doPush = !pushn && sz < D;
            doPop  = !popn && sz > 0;
            if (doPush) begin
                wrIdx         = (mdlRd + sz) % D;
                memA[wrIdx]   = d;
                memB[wrIdx]   = d;
                knownA[wrIdx] = 1'b1;
                knownB[wrIdx] = 1'b1;
            end
            if (doPop) begin
                void'(mdlQ.pop_front());
                mdlRd = (mdlRd + 1) % D;
            end
            if (doPush) mdlQ.push_back(d);
            errA = ovf || unf;
            errB = errB || ovf || unf;
        end
        sz       = mdlQ.size();
        expFlags = {sz == 0, sz <= 1, sz >= 2, sz >= 3, sz == D};
        expA     = (sz > 0) ? mdlQ[0] : memA[mdlRd];
        expB     = (sz > 0) ? mdlQ[0] : memB[mdlRd];
        #1;
        $display("t=%0t rst_n=%b push_n=%b pop_n=%b din=%h count=%0d doutA=%h doutB=%h errA=%b errB=%b",
                 $time, rstn, pushn, popn, d, sz, dataOutA, dataOutB, errorA, errorB);
        check("flagsA", {27'b0, emptyA, almostEmptyA, halfFullA, almostFullA, fullA}, {27'b0, expFlags});
        check("flagsB", {27'b0, emptyB, almostEmptyB, halfFullB, almostFullB, fullB}, {27'b0, expFlags});
        check("errorA", {31'b0, errorA}, {31'b0, errA});
        check("errorB", {31'b0, errorB}, {31'b0, errB});
        if (sz > 0 || knownA[mdlRd]) check("doutA", dataOutA, expA);
        if (sz > 0 || knownB[mdlRd]) check("doutB", dataOutB, expB);
    endtask

    initial begin
        logic [31:0] fillVals [4];
        fillVals   = '{32'h11, 32'h22, 32'h33, 32'h44};
        diag_n     = 1'b1;
        rst_n      = 1'b0;
        push_req_n = 1'b1;
        pop_req_n  = 1'b1;
        data_in    = '0;

        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, fillVals[i]);
        step(1, 0, 1, 32'hDEAD);
        step(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);

        step(1, 0, 1, 32'hA1);
        step(1, 0, 1, 32'hA2);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 32'hB1 + i);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

        step(1, 0, 1, 32'hC1);
        step(1, 0, 1, 32'hC2);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'hD1 + i);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 32'hE1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 32'hE2 + i);
        step(1, 0, 0, 32'hF1);
        step(1, 1, 1, 0);
        step(0, 0, 1, 32'h99);
        step(1, 1, 1, 0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
